// File: rtl/dmux_pkg.sv
// Shared constants and slot state encoding for the dmux_router block.
package dmux_pkg;
    localparam int DEF_N      = 10;
    localparam int DEF_SEL_W  = 4;
    localparam int DEF_DATA_W = 8;
    localparam int ERR_CNT_W  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_st_t;
endpackage

// File: rtl/dmux_chan_slot.sv
// One-entry holding slot for a single output channel of dmux_router.
module dmux_chan_slot
    import dmux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              valid,
    output logic [DATA_W-1:0] dout
);
    slot_st_t st;

    // A push into a FULL slot only happens alongside a pop, so it is a reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st   <= EMPTY;
            dout <= '0;
        end else if (push) begin
            st   <= FULL;
            dout <= din;
        end else if (pop) begin
            st   <= EMPTY;
        end
    end

    assign valid = (st == FULL);
endmodule

// File: rtl/dmux_router.sv
// 1-to-N valid/ready demux with a registered slot per channel and sticky
// out-of-range detection. Define DMUX_ERR_CNT_EN to add the err_cnt drop counter.
module dmux_router
    import dmux_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic [DATA_W-1:0]   in_data,
    output logic [N-1:0]        out_valid,
    input  logic [N-1:0]        out_ready,
    output logic [N*DATA_W-1:0] out_data,
`ifdef DMUX_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic                err_oor,
    input  logic                err_clr
);
    logic [N-1:0] hit;
    logic [N-1:0] push;
    logic         in_range;
    logic         acc;
    logic         oor_acc;

    // Selects with no matching channel fall through with ready = 1 and are dropped.
    always_comb begin
        hit      = '0;
        in_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                hit[k]   = 1'b1;
                in_ready = !out_valid[k] | out_ready[k];
            end
        end
    end

    assign in_range = |hit;
    assign acc      = in_valid & in_ready;
    assign oor_acc  = acc & !in_range;
    assign push     = hit & {N{acc}};

    for (genvar k = 0; k < N; k++) begin : g_chan
        dmux_chan_slot #(.DATA_W(DATA_W)) u_slot (
            .clk   (clk),
            .reset (reset),
            .push  (push[k]),
            .pop   (out_ready[k]),
            .din   (in_data),
            .valid (out_valid[k]),
            .dout  (out_data[k*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        err_oor <= 1'b0;
        else if (oor_acc) err_oor <= 1'b1;
        else if (err_clr) err_oor <= 1'b0;
    end

`ifdef DMUX_ERR_CNT_EN
    // Clear and increment together leave a count of one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= oor_acc ? ERR_CNT_W'(1) : '0;
        else if (oor_acc && err_cnt != {ERR_CNT_W{1'b1}})
            err_cnt <= err_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dmux_router.sv
// Scoreboard bench for dmux_router: per-channel expected-data queues checked on the falling edge.
module tb_dmux_router;
    localparam int N = 10, SEL_W = 4, DW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel = '0;
    logic [DW-1:0]     in_data = '0;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready = '1;
    logic [N*DW-1:0]   out_data;
    logic              err_oor;
    logic              err_clr = 1'b0;
`ifdef DMUX_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    dmux_router #(.N(N), .SEL_W(SEL_W), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DMUX_ERR_CNT_EN
        .err_cnt   (err_cnt),
`endif
        .err_oor   (err_oor),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Scoreboard model: queue non-empty == slot FULL, head == expected data.
    logic [DW-1:0] q[N][$];
    logic          m_err = 1'b0;
    int            m_cnt = 0;

    always @(negedge clk) begin
        logic [N-1:0] mv;
        logic         exp_rdy;
        if (reset) begin
            for (int k = 0; k < N; k++) q[k].delete();
            m_err = 1'b0;
            m_cnt = 0;
            chk("rst_valid", 32'(out_valid), 32'(0));
        end else begin
            mv = '0;
            for (int k = 0; k < N; k++) mv[k] = (q[k].size() != 0);
            chk("valid", 32'(out_valid), 32'(mv));
            for (int k = 0; k < N; k++)
                if (q[k].size() != 0) chk($sformatf("data%0d", k), 32'(out_data[k*DW +: DW]), 32'(q[k][0]));
            chk("err_oor", 32'(err_oor), 32'(m_err));
`ifdef DMUX_ERR_CNT_EN
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
            exp_rdy = (int'(in_sel) < N) ? (q[in_sel].size() == 0 || out_ready[in_sel]) : 1'b1;
            if (in_valid) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            for (int k = 0; k < N; k++)
                if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
            if (in_valid && exp_rdy && int'(in_sel) < N) q[in_sel].push_back(in_data);
            if (in_valid && exp_rdy && int'(in_sel) >= N) begin
                m_err = 1'b1;
                if (err_clr) m_cnt = 1;
                else if (m_cnt < 255) m_cnt++;
            end else if (err_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
        end
    end

    task automatic wait_acc();
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 50) begin
                chk("acc_timeout", 32'(in_ready), 32'(1));
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input int sel, input int d);
        in_valid = 1'b1;
        in_sel   = SEL_W'(sel);
        in_data  = DW'(d);
        wait_acc();
    endtask

    initial begin
        int t0;
        logic lr;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // idle: ready for every in-range select
        for (int s = 0; s < N; s++) begin
            in_sel = SEL_W'(s);
            #1 chk("idle_rdy", 32'(in_ready), 32'(1));
        end
        chk("idle_data", 32'(out_data == '0), 32'(1));
        @(posedge clk); #1;

        // single route to channel 3
        send(3, 8'hA5);
        #1 chk("route3_valid", 32'(out_valid), 32'h008);
        chk("route3_data", 32'(out_data[3*DW +: DW]), 32'hA5);
        @(posedge clk); #1 chk("route3_empty", 32'(out_valid), 32'(0));

        // back-pressure on channel 5
        out_ready[5] = 1'b0;
        send(5, 8'h11);
        in_valid = 1'b1; in_sel = 4'd5; in_data = 8'h22;
        repeat (3) begin
            @(negedge clk);
            chk("bp_rdy", 32'(in_ready), 32'(0));
            chk("bp_hold", 32'(out_data[5*DW +: DW]), 32'h11);
        end
        @(posedge clk); #1 out_ready[5] = 1'b1;
        wait_acc();
        #1 chk("bp_new", 32'(out_data[5*DW +: DW]), 32'h22);
        @(posedge clk); #1;

        // streaming through a full channel 7
        out_ready[7] = 1'b0;
        send(7, 8'h00);
        out_ready[7] = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= 8; i++) send(7, i);
        chk("stream_cycles", 32'(cyc - t0), 32'(8));
        repeat (2) @(posedge clk); #1;

        // out-of-range drop, sticky flag, clear, set-beats-clear
        send(12, 8'h5A);
        #1 chk("oor_flag", 32'(err_oor), 32'(1));
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        chk("oor_clr", 32'(err_oor), 32'(0));
        err_clr = 1'b1;
        send(13, 8'h77);
        err_clr = 1'b0;
        chk("oor_set_wins", 32'(err_oor), 32'(1));

        // 300 back-to-back drops saturate the counter
        in_valid = 1'b1; in_sel = 4'd12;
        repeat (300) @(posedge clk);
        #1 in_valid = 1'b0;
`ifdef DMUX_ERR_CNT_EN
        chk("cnt_sat", 32'(err_cnt), 32'(255));
`endif
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;

        // random traffic, holding sel/data while stalled
        lr = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && !lr)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = SEL_W'($urandom_range(0, 15));
                in_data  = DW'($urandom);
            end
            out_ready = N'($urandom);
            err_clr   = ($urandom_range(0, 15) == 0);
            @(negedge clk); lr = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; err_clr = 1'b0; out_ready = '1;
        repeat (2) @(posedge clk); #1;

        // asynchronous reset with channels 0 and 9 full
        out_ready[0] = 1'b0; out_ready[9] = 1'b0;
        send(0, 8'hC3);
        send(9, 8'h3C);
        chk("pre_rst", 32'(out_valid), 32'h201);
        #2 reset = 1'b1;
        #1 chk("async_rst_valid", 32'(out_valid), 32'(0));
        chk("async_rst_data", 32'(out_data == '0), 32'(1));
        @(posedge clk); #1 reset = 1'b0;
        out_ready = '1;
        send(2, 8'h5E);
        #1 chk("post_rst_route", 32'(out_data[2*DW +: DW]), 32'h5E);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
